// File: rtl/sauria_rst_pkg.sv
// Shared types and helpers for the SAURIA reset sequencer.
package sauria_rst_pkg;

  // Widest configuration the sequencer supports.
  localparam int unsigned MAX_DOMAINS = 16;
  localparam int unsigned MAX_IDX_W   = 4;
  // One extra bit so a search start one past the top domain stays representable.
  localparam int unsigned FROM_W      = MAX_IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    HOLD,
    RELEASE,
    DONE
  } rst_state_e;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } bit_sel_t;

  // Lowest set bit of mask at position >= from_idx; valid=0 when none exists.
  function automatic bit_sel_t next_set_bit(input logic [MAX_DOMAINS-1:0] mask,
                                            input logic [FROM_W-1:0]      from_idx);
    bit_sel_t res;
    res = '0;
    // Scan downwards so the last hit written is the lowest qualifying bit.
    for (int i = MAX_DOMAINS - 1; i >= 0; i--) begin
      if (mask[i] && (FROM_W'(i) >= from_idx)) begin
        res.valid = 1'b1;
        res.idx   = MAX_IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sauria_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases synchronously.
module sauria_rst_sync (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_sync_no
);

  logic [1:0] sync_q;

  // Shift a constant 1 through two flops once the raw reset lifts.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync_no = sync_q[1];

endmodule

// File: rtl/sauria_reset_sequencer.sv
// SAURIA reset sequencer: power-on and software-triggered reset sequencing of
// NUM_DOMAINS domains. Selected domains are asserted together, held, then
// released one by one in ascending index order.
module sauria_reset_sequencer
  import sauria_rst_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = 2,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned STAGGER_CYCLES = 2
) (
  input  logic                   i_system_clk,
  input  logic                   i_system_rstn,
  input  logic                   i_sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] i_domain_mask,
  output logic [NUM_DOMAINS-1:0] o_domain_rstn,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  rst_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] act_mask_q, act_mask_d;
  logic [NUM_DOMAINS-1:0] pend_mask_q, pend_mask_d;
  logic                   pend_q, pend_d;
  logic [NUM_DOMAINS-1:0] rstn_q, rstn_d;

  logic     rst_sync_n;
  bit_sel_t first_sel;
  bit_sel_t next_sel;
  logic     sel_unused;

  sauria_rst_sync u_rst_sync (
    .clk_i       (i_system_clk),
    .rst_ni      (i_system_rstn),
    .rst_sync_no (rst_sync_n)
  );

  // Release order: first selected domain, and the one after the current index.
  assign first_sel = next_set_bit(MAX_DOMAINS'(act_mask_q), '0);
  assign next_sel  = next_set_bit(MAX_DOMAINS'(act_mask_q), FROM_W'(idx_q) + FROM_W'(1));
  // Upper index bits beyond IDX_W are never set for this configuration.
  assign sel_unused = ^{first_sel, next_sel};

  // Next-state logic: sequence control plus request accumulation while busy.
  // NOTE: every variable gets its hold value before the case statement, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    act_mask_d  = act_mask_q;
    pend_mask_d = pend_mask_q;
    pend_d      = pend_q;
    rstn_d      = rstn_q;

    // A request arriving mid-sequence is queued; it never widens act_mask.
    if ((state_q != IDLE) && i_sw_rst_req) begin
      pend_d      = 1'b1;
      pend_mask_d = pend_mask_q | i_domain_mask;
    end

    unique case (state_q)
      IDLE: begin
        if (i_sw_rst_req && (i_domain_mask != '0)) begin
          act_mask_d = i_domain_mask;
          state_d    = ASSERT;
        end
      end
      ASSERT: begin
        rstn_d  = rstn_q & ~act_mask_q;
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          idx_d   = IDX_W'(first_sel.idx);
          rstn_d  = rstn_q | (NUM_DOMAINS'(1) << IDX_W'(first_sel.idx));
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == STAGGER_LAST) begin
          if (next_sel.valid) begin
            idx_d  = IDX_W'(next_sel.idx);
            rstn_d = rstn_q | (NUM_DOMAINS'(1) << IDX_W'(next_sel.idx));
            cnt_d  = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // Pending requests chain straight into a new ASSERT; an empty mask is dropped.
        if (pend_d && (pend_mask_d != '0)) begin
          act_mask_d = pend_mask_d;
          state_d    = ASSERT;
        end else begin
          state_d = IDLE;
        end
        pend_d      = 1'b0;
        pend_mask_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register: raw reset forces the power-on HOLD at once; the FSM only
  // advances once the synchronised reset has lifted.
  always_ff @(posedge i_system_clk or negedge i_system_rstn) begin
    if (!i_system_rstn) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      act_mask_q  <= '1;
      pend_mask_q <= '0;
      pend_q      <= 1'b0;
      rstn_q      <= '0;
    end else if (rst_sync_n) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_mask_q  <= act_mask_d;
      pend_mask_q <= pend_mask_d;
      pend_q      <= pend_d;
      rstn_q      <= rstn_d;
    end
  end

  assign o_domain_rstn = rstn_q;
  assign o_busy        = (state_q != IDLE);
  assign o_done        = (state_q == DONE);

endmodule

// File: tb/tb_sauria_reset_sequencer.sv
// Scoreboard bench for sauria_reset_sequencer. Two instances share stimulus:
// a 4-domain (H=4,S=2) and a 1-domain (H=1,S=1) configuration. A timeline
// model predicts the outputs after every clock edge; a monitor on the falling
// edge pops and compares.
module tb_sauria_reset_sequencer;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       req  = 1'b0;
  logic [3:0] mask = 4'b0000;

  logic [3:0] d0_rstn;
  logic       d0_busy, d0_done;
  logic [0:0] d1_rstn;
  logic       d1_busy, d1_done;

  always #5 clk = ~clk;

  sauria_reset_sequencer #(
    .NUM_DOMAINS(4), .HOLD_CYCLES(4), .STAGGER_CYCLES(2)
  ) u_dut (
    .i_system_clk  (clk),
    .i_system_rstn (rstn),
    .i_sw_rst_req  (req),
    .i_domain_mask (mask),
    .o_domain_rstn (d0_rstn),
    .o_busy        (d0_busy),
    .o_done        (d0_done)
  );

  sauria_reset_sequencer #(
    .NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)
  ) u_dut_small (
    .i_system_clk  (clk),
    .i_system_rstn (rstn),
    .i_sw_rst_req  (req),
    .i_domain_mask (mask[0:0]),
    .o_domain_rstn (d1_rstn),
    .o_busy        (d1_busy),
    .o_done        (d1_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got rstn/busy/done=%b expected %b", name, $time, got, exp);
    end
  endtask

  // ---------------- timeline reference model ----------------
  // Sequence started at edge t0 (request sampled): selected bits low after t0+1,
  // k-th selected bit high after t0+1+H+k*S, done during the cycle after
  // t0+1+H+m*S, sequence over at the following edge.
  int         m_n[2], m_h[2], m_s[2];
  int         m_t[2], m_t0[2];
  bit         m_on[2], m_done[2];
  logic [3:0] m_act[2], m_pend[2], m_rstn[2];
  logic [5:0] exp_q0[$];
  logic [5:0] exp_q1[$];

  function automatic logic [3:0] full_mask(input int i);
    return 4'((1 << m_n[i]) - 1);
  endfunction

  task automatic model_reset(input int i);
    m_t[i]    = 0;
    m_on[i]   = 1'b1;
    m_t0[i]   = 1;    // power-on behaves as if ASSERT took effect at edge 2
    m_act[i]  = full_mask(i);
    m_pend[i] = '0;
    m_rstn[i] = '0;
    m_done[i] = 1'b0;
  endtask

  task automatic model_step(input int i, input bit r, input logic [3:0] mk_in);
    logic [3:0] mk;
    int t, k, done_e;
    mk = mk_in & full_mask(i);
    m_t[i]++;
    t = m_t[i];
    m_done[i] = 1'b0;
    if (!m_on[i]) begin
      if (t > 2 && r && mk != 0) begin
        m_on[i]  = 1'b1;
        m_t0[i]  = t;
        m_act[i] = mk;
      end
    end else begin
      // edges 1 and 2 after reset release are frozen by the synchroniser
      if (t > 2 && r && t >= m_t0[i] + 1) m_pend[i] = m_pend[i] | mk;
      if (t == m_t0[i] + 1) m_rstn[i] = m_rstn[i] & ~m_act[i];
      k = 0;
      for (int b = 0; b < m_n[i]; b++) begin
        if (m_act[i][b]) begin
          if (t == m_t0[i] + 1 + m_h[i] + k * m_s[i]) m_rstn[i][b] = 1'b1;
          k++;
        end
      end
      done_e = m_t0[i] + 1 + m_h[i] + k * m_s[i];
      if (t == done_e) m_done[i] = 1'b1;
      if (t == done_e + 1) begin
        m_on[i] = 1'b0;
        if (m_pend[i] != 0) begin
          m_on[i]  = 1'b1;
          m_t0[i]  = t;
          m_act[i] = m_pend[i];
        end
        m_pend[i] = '0;
      end
    end
  endtask

  // Predict after every rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn) model_reset(i);
      else       model_step(i, req, mask);
      if (i == 0) exp_q0.push_back({m_rstn[0], m_on[0], m_done[0]});
      else        exp_q1.push_back({m_rstn[1], m_on[1], m_done[1]});
    end
  end

  // Monitor: compare DUT outputs against the predictions on the falling edge.
  always @(negedge clk) begin
    logic [5:0] e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      check("dut4", {d0_rstn, d0_busy, d0_done}, e);
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      check("dut1", {3'b000, d1_rstn, d1_busy, d1_done}, e);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input logic [3:0] m);
    @(negedge clk);
    #2;
    req  = r;
    mask = m;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'b0000);
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    req  = 1'b0;
    mask = 4'b0000;
    #1;
    check("async_reset_dut4", {d0_rstn, d0_busy, d0_done}, 6'b000010);
    check("async_reset_dut1", {3'b000, d1_rstn, d1_busy, d1_done}, 6'b000010);
    repeat (hold) @(negedge clk);
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    m_n[0] = 4; m_h[0] = 4; m_s[0] = 2;
    m_n[1] = 1; m_h[1] = 1; m_s[1] = 1;
    model_reset(0);
    model_reset(1);

    // power-on sequence
    repeat (3) @(negedge clk);
    #2;
    rstn = 1'b1;
    idle(20);

    // single request, sparse mask
    drive(1'b1, 4'b1010);
    idle(14);

    // request queued during a running sequence
    drive(1'b1, 4'b0110);
    idle(3);
    drive(1'b1, 4'b0001);
    idle(25);

    // empty mask is ignored
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b0000);
    idle(6);

    // reset in HOLD with a pending request
    drive(1'b1, 4'b1111);
    idle(1);
    drive(1'b1, 4'b0010);
    pulse_reset(3);
    idle(25);

    // back-to-back requests
    repeat (24) drive(1'b1, 4'b0001);
    idle(20);

    // randomized traffic with rare resets
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset($urandom_range(1, 4));
      else drive(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
    end
    idle(40);

    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
